// File: rtl/mem_bridge_ctrl_if.sv
// Requester and memory-side signal bundle for mem_bridge_ctrl.
// master = requester/memory side, slave = the controller.
interface mem_bridge_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [15:0] AddrBus;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  MemDataOut;
  logic [7:0]  MemDataIn;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready, MemDataIn,
    input  req_ready, AddrBus, mem_en, mem_we,
    input  MemDataOut, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready, MemDataIn,
    output req_ready, AddrBus, mem_en, mem_we,
    output MemDataOut, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bridge_ctrl.sv
// Single-outstanding request bridge to a registered-read memory block.
// Define MEMBRIDGE_ROM_PROTECT_EN to refuse writes below 0x8000.
module mem_bridge_ctrl (
  input logic              clk,
  input logic              rst_n,
  mem_bridge_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, CAPTURE, RESP
  } state_t;

  state_t      state;
  state_t      stateNxt;
  logic [15:0] addrQ;
  logic [7:0]  wdataQ;
  logic [7:0]  rdataQ;
  logic        weQ;
  logic        errQ;
  logic        accept;
  logic        memEn;

  assign accept = bus.req_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addrQ  <= 16'h0000;
      wdataQ <= 8'h00;
      rdataQ <= 8'h00;
      weQ    <= 1'b0;
    end else begin
      state <= stateNxt;
      if (accept) begin
        addrQ  <= bus.req_addr;
        wdataQ <= bus.req_wdata;
        weQ    <= bus.req_we;
      end
      if (state == CAPTURE)
        rdataQ <= bus.MemDataIn;
    end
  end

`ifdef MEMBRIDGE_ROM_PROTECT_EN
  // Lower half is ROM: the write still walks the FSM but never reaches memory.
  always_ff @(posedge clk) begin
    if (!rst_n)
      errQ <= 1'b0;
    else if (accept)
      errQ <= bus.req_we && !bus.req_addr[15];
  end
`else
  assign errQ = 1'b0;
`endif

  always_comb begin
    stateNxt = state;
    memEn    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid)
          stateNxt = ISSUE;
      end
      ISSUE: begin
        memEn    = !errQ;
        stateNxt = weQ ? RESP : CAPTURE;
      end
      CAPTURE: begin
        stateNxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready)
          stateNxt = IDLE;
      end
      default: begin
        stateNxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.AddrBus    = addrQ;
  assign bus.MemDataOut = wdataQ;
  assign bus.mem_en     = memEn;
  assign bus.mem_we     = memEn && weQ;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_rdata  = rdataQ;
  assign bus.rsp_err    = (state == RESP) && errQ;

endmodule

// File: tb/tb_mem_bridge_ctrl.sv
// Scoreboard bench for mem_bridge_ctrl with a behavioural memory.
// Honours MEMBRIDGE_ROM_PROTECT_EN for write-refusal expectations.
module tb_mem_bridge_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bridge_ctrl_if bus();

  mem_bridge_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem    [65536];
  logic [7:0] shadow [65536];
  rsp_t       sb[$];
  logic [7:0] lastRd;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Registered-read memory: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we)
        mem[bus.AddrBus] <= bus.MemDataOut;
      else
        bus.MemDataIn <= mem[bus.AddrBus];
    end
  end

  function automatic bit refused(input bit we, input logic [15:0] a);
`ifdef MEMBRIDGE_ROM_PROTECT_EN
    return we && !a[15];
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkReset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_mem_en"}, bus.mem_en, 0);
    check({tag, "_mem_we"}, bus.mem_we, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_addr"}, bus.AddrBus, 16'h0000);
    check({tag, "_wdata"}, bus.MemDataOut, 8'h00);
    check({tag, "_rdata"}, bus.rsp_rdata, 8'h00);
  endtask

  task automatic access(input bit we, input logic [15:0] a,
                        input logic [7:0] d, input int stallIn);
    bit   err;
    bit   done;
    int   stall;
    int   enCnt;
    int   enCyc;
    int   weCnt;
    int   lat;
    rsp_t exp;
    rsp_t got;
    err   = refused(we, a);
    done  = 1'b0;
    stall = stallIn;
    enCnt = 0;
    enCyc = 0;
    weCnt = 0;
    lat   = 0;
    exp.err = err;
    if (we) begin
      if (!err) shadow[a] = d;
      exp.rdata = lastRd;
    end else begin
      exp.rdata = shadow[a];
      lastRd    = shadow[a];
    end
    sb.push_back(exp);
    @(negedge clk);
    check("req_ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      if (stallIn > 0)
        bus.req_addr = bus.req_addr ^ 16'h5A5A;
      else
        bus.req_valid = 1'b0;
      if (c == 1) begin
        check("addr_bus", bus.AddrBus, a);
        check("mem_dout", bus.MemDataOut, d);
      end
      if (bus.mem_en) begin
        enCnt++;
        enCyc = c;
      end
      if (bus.mem_we) weCnt++;
      if (bus.rsp_valid) begin
        if (lat == 0) begin
          lat = c;
          got = {bus.rsp_rdata, bus.rsp_err};
          if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
          end else begin
            exp = sb.pop_front();
            check("rsp_rdata", got.rdata, exp.rdata);
            check("rsp_err", got.err, exp.err);
          end
        end else begin
          check("hold_rdata", bus.rsp_rdata, exp.rdata);
          check("hold_err", bus.rsp_err, exp.err);
          check("hold_ready", bus.req_ready, 0);
          check("hold_addr", bus.AddrBus, a);
        end
        if (stall > 0) begin
          bus.rsp_ready = 1'b0;
          stall--;
        end else begin
          bus.rsp_ready = 1'b1;
          @(posedge clk);
          #1;
          bus.rsp_ready = 1'b0;
          bus.req_valid = 1'b0;
          done = 1'b1;
        end
      end
    end
    if (!done) begin
      check("rsp_timeout", 0, 1);
      bus.req_valid = 1'b0;
    end
    check("latency", lat, (we || err) ? 2 : 3);
    check("mem_en_cnt", enCnt, err ? 0 : 1);
    check("mem_en_cyc", enCyc, err ? 0 : 1);
    check("mem_we_cnt", weCnt, (we && !err) ? 1 : 0);
  endtask

  task automatic resetMidAccess();
    int vCnt;
    vCnt = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h9000;
    bus.req_wdata = 8'h33;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("mid_issue_en", bus.mem_en, 1);
    rst_n = 1'b0;
    @(negedge clk);
    checkReset("mid_rst");
    rst_n  = 1'b1;
    lastRd = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) vCnt++;
    end
    check("mid_no_rsp", vCnt, 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 16'h0000;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b0;
    bus.MemDataIn = 8'h00;
    for (int i = 0; i < 65536; i++) begin
      mem[i]    = 8'(i) ^ 8'(i >> 8);
      shadow[i] = 8'(i) ^ 8'(i >> 8);
    end
    mem[16'h8123]    = 8'h5A;
    shadow[16'h8123] = 8'h5A;
    lastRd = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;

    access(1'b0, 16'h8123, 8'h00, 0);
    access(1'b1, 16'hFFFF, 8'hA5, 0);
    access(1'b0, 16'hFFFF, 8'h00, 0);
    access(1'b0, 16'h8123, 8'h3C, 5);
    access(1'b1, 16'h0010, 8'h77, 0);
    access(1'b0, 16'h0010, 8'h00, 0);
    for (int k = 0; k < 8; k++)
      access(1'($urandom_range(1)), 16'($urandom),
             8'($urandom), int'($urandom_range(2)));

    resetMidAccess();
    access(1'b0, 16'h8123, 8'h00, 0);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge_ctrl.md
MEM_BRIDGE_CTRL -- requirements
Module: mem_bridge_ctrl

Interface
REQ-001 SHALL provide port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL provide port: req_valid  input  1  requester offers a memory access.
REQ-004 SHALL provide port: req_ready  output  1  controller can accept a request this cycle.
REQ-005 SHALL provide port: req_we  input  1  1 = write, 0 = read.
REQ-006 SHALL provide port: req_addr  input  16  byte address.
REQ-007 SHALL provide port: req_wdata  input  8  write data.
REQ-008 SHALL provide port: AddrBus  output  16  registered address to the memory block.
REQ-009 SHALL provide port: mem_en  output  1  memory enable, one-cycle pulse per access.
REQ-010 SHALL provide port: mem_we  output  1  memory write enable, only asserted together with mem_en.
REQ-011 SHALL provide port: MemDataOut  output  8  registered write data to the memory.
REQ-012 SHALL provide port: MemDataIn  input  8  memory registered read data, valid the cycle after a mem_en read cycle.
REQ-013 SHALL provide port: rsp_valid  output  1  access complete; rsp_rdata valid for reads.
REQ-014 SHALL provide port: rsp_ready  input  1  requester consumes the response.
REQ-015 SHALL provide port: rsp_rdata  output  8  captured read data; holds last value otherwise.
REQ-016 SHALL provide port: rsp_err  output  1  access refused, only meaningful with rsp_valid.

Function
REQ-017 SHALL implement states IDLE, ISSUE, CAPTURE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL on req_valid & req_ready at edge N register req_addr into AddrBus, req_wdata into MemDataOut, latch req_we, and go to ISSUE.
REQ-019 SHALL in ISSUE drive mem_en = 1, and mem_we = latched we, for exactly one cycle (N+1); mem_en = mem_we = 0 in every other state.
REQ-020 SHALL for a read go ISSUE -> CAPTURE; in CAPTURE (cycle N+2) sample MemDataIn into rsp_rdata at edge N+3 and go to RESP.
REQ-021 SHALL for a write go ISSUE -> RESP directly; rsp_rdata unchanged by writes.
REQ-022 SHALL assert rsp_valid only in RESP: read latency = 3 cycles (rsp_valid from N+3), write latency = 2 cycles (from N+2).
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE at that edge.
REQ-024 SHALL NOT accept a new request in the cycle a response handshakes; next acceptance is earliest one cycle later (read throughput 1 per 4 cycles minimum).
REQ-025 SHALL ignore req_* changes while not in IDLE; AddrBus and MemDataOut hold their values until the next acceptance.
REQ-026 SHALL treat addresses as a flat 16-bit space 0x0000-0xFFFF with no wrap or arithmetic; 0xFFFF is a legal address.
REQ-027 SHALL ignore rsp_ready outside RESP.

Reset
REQ-028 SHALL on rst_n = 0 at a clock edge enter IDLE regardless of current state, including mid-access.
REQ-029 SHALL reset values: req_ready = 1 after the reset edge, mem_en = 0, mem_we = 0, rsp_valid = 0, rsp_err = 0, AddrBus = 0x0000, MemDataOut = 0x00, rsp_rdata = 0x00.
REQ-030 SHALL, when reset hits during ISSUE, suppress mem_en from the following cycle; no response is produced for the aborted access.

Configuration
REQ-031 SHALL compile in ROM write protection when macro MEMBRIDGE_ROM_PROTECT_EN is defined.
REQ-032 With MEMBRIDGE_ROM_PROTECT_EN defined: a write with req_addr[15] = 0 (0x0000-0x7FFF) SHALL go IDLE -> ISSUE with mem_en = mem_we = 0 in ISSUE, then RESP with rsp_err = 1; reads and writes to 0x8000-0xFFFF SHALL behave as REQ-018..023 with rsp_err = 0.
REQ-033 Without MEMBRIDGE_ROM_PROTECT_EN: rsp_err SHALL be constant 0 and all writes SHALL be issued.

Verification
REQ-034 Read: after reset, req addr 0x8123 read, MemDataIn = 0x5A at N+2 -> mem_en pulse at N+1 only, rsp_valid at N+3, rsp_rdata = 0x5A, rsp_err = 0.
REQ-035 Write: addr 0xFFFF data 0xA5 -> AddrBus = 0xFFFF, MemDataOut = 0xA5, mem_en = mem_we = 1 at N+1 only, rsp_valid at N+2, rsp_rdata unchanged.
REQ-036 Backpressure: hold rsp_ready = 0 for 5 cycles in RESP with req_valid = 1 and changing req_addr -> rsp_valid/rsp_rdata stable, req_ready = 0, AddrBus unchanged, no extra mem_en.
REQ-037 Reset mid-access: rst_n = 0 during ISSUE of a read -> next cycle mem_en = 0, rsp_valid never asserts, all outputs at REQ-029 values, req_ready = 1.
REQ-038 Protection (MEMBRIDGE_ROM_PROTECT_EN defined): write 0x0010 data 0x77 -> no mem_en/mem_we pulse, rsp_valid at N+2 with rsp_err = 1; without macro same stimulus -> mem_we pulse, rsp_err = 0.
